seven_segment_capture: RTL

Receive-side counterpart to the multiplexed seven-segment driver: it watches a display's active-low `anode`/`cathode` bus, waits for each digit's strobe to settle, and decodes the cathode pattern back into a 4-bit hex nibble plus decimal-point bit per digit. It sits on the board-level display bus, or in loopback on a bench. Counters and self-checks use it to read back what a display is showing without a camera or a scope. It also reports frame completion and non-font patterns.

---
 rtl/seven_segment_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - decodes a multiplexed active-low seven-segment bus back into hex digits
//
// Optional feature: define SEG_CAPTURE_ERRCNT_EN to add the err_count output.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   anode        digit strobes, active low, one bit per digit
//   cathode      segments, active low; bit0=A .. bit6=G, bit7=dot
//   encoded      last decoded nibble per digit
//   digit_point  last captured dot per digit, 1 = lit
//   digit_valid  digit captured with a legal font pattern since reset
//   frame_done   one-cycle pulse when every digit has been captured since the last pulse
//   bad_pattern  one-cycle pulse when a captured segment pattern is not in the font
//   err_count    (SEG_CAPTURE_ERRCNT_EN only) saturating count of bad patterns and multi-strobe entries

module seven_segment_capture #(
    parameter int NUM_SEGMENTS  = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SEGMENTS-1:0]      anode,
    input  logic [7:0]                   cathode,
    output logic [NUM_SEGMENTS-1:0][3:0] encoded,
    output logic [NUM_SEGMENTS-1:0]      digit_point,
    output logic [NUM_SEGMENTS-1:0]      digit_valid,
    output logic                         frame_done,
`ifdef SEG_CAPTURE_ERRCNT_EN
    output logic                         bad_pattern,
    output logic [7:0]                   err_count
`else
    output logic                         bad_pattern
`endif
);

    localparam logic [7:0]              SETTLE   = 8'(SETTLE_CYCLES);
    localparam logic [NUM_SEGMENTS-1:0] ALL_SEEN = '1;

    logic [NUM_SEGMENTS-1:0] anode_q;
    logic [7:0]              cathode_q;
    logic [NUM_SEGMENTS-1:0] anode_prev;
    logic [7:0]              cathode_prev;
    logic [7:0]              cnt;
    logic                    cap_flag;
    logic [NUM_SEGMENTS-1:0] seen;

    logic [3:0]              zeros;
    logic                    legal;
    logic                    multi;
    logic                    changed;
    logic                    capture;
    logic [NUM_SEGMENTS-1:0] strobe;
    logic [6:0]              lit;
    logic [3:0]              nibble;
    logic                    font_ok;

    always_comb begin
        zeros = 4'd0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (!anode_q[i]) begin
                zeros = zeros + 4'd1;
            end
        end
    end

    assign legal   = (zeros == 4'd1);
    assign multi   = (zeros > 4'd1);
    assign changed = (anode_q != anode_prev) || (cathode_q != cathode_prev);

    // cnt counts how many consecutive samples of the pattern now held in
    // anode_prev/cathode_prev were identical and legal. When it reaches
    // SETTLE the dwell is complete, so the capture reads the *_prev copy:
    // a dwell of exactly SETTLE samples is captured even if the bus moves on
    // in the very cycle the decision is made.
    assign capture = (cnt == SETTLE) && !cap_flag;
    assign strobe  = ~anode_prev;
    assign lit     = ~cathode_prev[6:0];

    always_comb begin
        nibble  = 4'h0;
        font_ok = 1'b1;
        case (lit)
            7'h3F:   nibble = 4'h0;
            7'h06:   nibble = 4'h1;
            7'h5B:   nibble = 4'h2;
            7'h4F:   nibble = 4'h3;
            7'h66:   nibble = 4'h4;
            7'h6D:   nibble = 4'h5;
            7'h7D:   nibble = 4'h6;
            7'h07:   nibble = 4'h7;
            7'h7F:   nibble = 4'h8;
            7'h6F:   nibble = 4'h9;
            7'h77:   nibble = 4'hA;
            7'h7C:   nibble = 4'hB;
            7'h39:   nibble = 4'hC;
            7'h5E:   nibble = 4'hD;
            7'h79:   nibble = 4'hE;
            7'h71:   nibble = 4'hF;
            default: font_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q      <= '1;
            cathode_q    <= '1;
            anode_prev   <= '1;
            cathode_prev <= '1;
            cnt          <= 8'd0;
            cap_flag     <= 1'b0;
            seen         <= '0;
            encoded      <= '0;
            digit_point  <= '0;
            digit_valid  <= '0;
            frame_done   <= 1'b0;
            bad_pattern  <= 1'b0;
        end else begin
            anode_q      <= anode;
            cathode_q    <= cathode;
            anode_prev   <= anode_q;
            cathode_prev <= cathode_q;
            frame_done   <= 1'b0;
            bad_pattern  <= 1'b0;

            // Idle and any change both start a fresh dwell; the capture flag
            // only survives while the bus holds still.
            if (!legal) begin
                cnt      <= 8'd0;
                cap_flag <= 1'b0;
            end else if (changed || cnt == 8'd0) begin
                cnt      <= 8'd1;
                cap_flag <= 1'b0;
            end else begin
                if (cnt < SETTLE) begin
                    cnt <= cnt + 8'd1;
                end
                if (capture) begin
                    cap_flag <= 1'b1;
                end
            end

            if (capture) begin
                for (int i = 0; i < NUM_SEGMENTS; i++) begin
                    if (strobe[i]) begin
                        digit_point[i] <= ~cathode_prev[7];
                        if (font_ok) begin
                            encoded[i]     <= nibble;
                            digit_valid[i] <= 1'b1;
                        end
                    end
                end
                if (!font_ok) begin
                    bad_pattern <= 1'b1;
                end
                if ((seen | strobe) == ALL_SEEN) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen | strobe;
                end
            end
        end
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic multi_prev;

    // Multi-strobe counts once per entry, not once per cycle held.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= 8'd0;
            multi_prev <= 1'b0;
        end else begin
            multi_prev <= multi;
            if (((capture && !font_ok) || (multi && !multi_prev)) && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
